// File: rtl/axis_sync_fifo_stat_if.sv
// AXI-Stream handshake bundle shared by the stream FIFO family.
//   tvalid : producer has a word on tdata
//   tready : consumer accepts the word this cycle
//   tdata  : payload, TDATA_WIDTH bits
// Modport m is the producer side, s is the consumer side.
interface axis_if #(
  parameter int TDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_sync_fifo_stat.sv
// Synchronous AXI-Stream FIFO with live occupancy, almost-full/almost-empty
// flags and a synchronous flush. Storage is an output register that drives
// axis_mif directly, backed by a DEPTH-1 entry asynchronous-read RAM whose
// pointers wrap explicitly, so any DEPTH >= 2 is supported.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (priority over flush)
//   axis_sif     : input stream (consumer side)
//   axis_mif     : output stream (producer side), same width as axis_sif
//   flush        : synchronous discard of all contents
//   count        : current occupancy including the output register
//   almost_full  : count >= AFULL_THRESH
//   almost_empty : count <= AEMPTY_THRESH
// Every output is a register; axis_mif.tready only reaches axis_sif.tready
// through the registered count.
module axis_sync_fifo_stat #(
  parameter  int unsigned DEPTH         = 5,
  parameter  int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter  int unsigned AEMPTY_THRESH = 1,
  localparam int unsigned CW            = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  axis_if.s             axis_sif,
  axis_if.m             axis_mif,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam int unsigned W    = $bits(axis_sif.tdata);
  localparam int unsigned RD   = DEPTH - 1;
  localparam int unsigned ADDR = (RD > 1) ? $clog2(RD) : 1;

  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]   AE_C    = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0]   TWO_C   = CW'(2);
  localparam logic [ADDR-1:0] LAST_C  = ADDR'(DEPTH - 2);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "axis_sync_fifo_stat: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $fatal(1, "axis_sync_fifo_stat: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "axis_sync_fifo_stat: AEMPTY_THRESH must be in 0..DEPTH-1");
  end
  if ($bits(axis_sif.tdata) != $bits(axis_mif.tdata)) begin : g_bad_width
    $fatal(1, "axis_sync_fifo_stat: axis_sif and axis_mif widths differ");
  end

  logic [W-1:0]    ram [RD];
  logic [ADDR-1:0] wptr;
  logic [ADDR-1:0] rptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            tvalid_q;
  logic [W-1:0]    tdata_q;
  logic            tready_q;

  logic push;
  logic pop;
  logic ram_empty;
  logic direct;
  logic ram_wr;
  logic ram_rd;

  function automatic logic [ADDR-1:0] next_ptr(input logic [ADDR-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // The output register always fills first, so RAM occupancy is count-1
  // whenever count is non-zero; the RAM is empty exactly when count < 2.
  always_comb begin
    push      = axis_sif.tvalid && tready_q;
    pop       = tvalid_q && axis_mif.tready;
    ram_empty = (count_q < TWO_C);
    direct    = !tvalid_q || (pop && ram_empty);
    ram_wr    = push && !direct;
    ram_rd    = pop && !ram_empty;
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (ram_wr && !rst && !flush) begin
      ram[wptr] <= axis_sif.tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tready_q     <= 1'b0;
      count_q      <= '0;
      wptr         <= '0;
      rptr         <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      // tdata_q is left untouched; tvalid_q = 0 already hides it.
      tvalid_q     <= 1'b0;
      tready_q     <= 1'b1;
      count_q      <= '0;
      wptr         <= '0;
      rptr         <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count_q      <= count_d;
      tready_q     <= (count_d < DEPTH_C);
      almost_full  <= (count_d >= AF_C);
      almost_empty <= (count_d <= AE_C);

      if (ram_wr) begin
        wptr <= next_ptr(wptr);
      end

      if (ram_rd) begin
        tdata_q  <= ram[rptr];
        tvalid_q <= 1'b1;
        rptr     <= next_ptr(rptr);
      end else if (push && direct) begin
        tdata_q  <= axis_sif.tdata;
        tvalid_q <= 1'b1;
      end else if (pop) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign axis_sif.tready = tready_q;
  assign axis_mif.tvalid = tvalid_q;
  assign axis_mif.tdata  = tdata_q;
  assign count           = count_q;

endmodule

// File: doc/axis_sync_fifo_stat.md
Name: axis_sync_fifo_stat

Overview:
Synchronous AXI-Stream FIFO, next generation of the stream FIFO family.
- Supports any DEPTH ≥ 2, not just powers of 2 plus 1.
- Exposes live occupancy and programmable almost-full / almost-empty flags.
- Implements a real synchronous flush.
- Sits between pipeline stages (fetch/decode queues, LSU buffers) where back-pressure lookahead and flush-on-redirect are needed.

Parameters:
DEPTH, 5, total entries (output register + DEPTH-1 RAM entries); legal range ≥ 2
AFULL_THRESH, DEPTH-1, almost_full asserts when count ≥ AFULL_THRESH; legal 1..DEPTH
AEMPTY_THRESH, 1, almost_empty asserts when count ≤ AEMPTY_THRESH; legal 0..DEPTH-1
CW (localparam), $clog2(DEPTH+1), occupancy counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
axis_sif  axis_if.s  TDATA_WIDTH  input stream; TDATA_WIDTH taken from the interface
axis_mif  axis_if.m  TDATA_WIDTH  output stream; width must equal axis_sif (elaboration $fatal otherwise)
flush  input  1  synchronous discard of all contents
count  output  CW  current occupancy, including the output register
almost_full  output  1  count ≥ AFULL_THRESH
almost_empty  output  1  count ≤ AEMPTY_THRESH

Behaviour:
- Storage: one output register (tvalid_q/tdata_q) drives axis_mif directly, backed by an asynchronous-read RAM of DEPTH-1 entries.
- RAM pointers are ADDR-wide and wrap explicitly DEPTH-2 → 0; no power-of-2 assumption.
- Occupancy uses a separate count register, not pointer MSB comparison.
- All outputs are registered:
  - axis_sif.tready = tready_q.
  - axis_mif.tvalid/tdata = output register.
  - count, almost_full and almost_empty are derived from the count register only.
  - No combinational path from axis_mif.tready to axis_sif.tready.
- Push = axis_sif.tvalid && tready_q. Pop = axis_mif.tvalid && axis_mif.tready.
- count_d = count + push - pop.
- tready_d = (count_d < DEPTH). Full therefore blocks the input the cycle after the last push.
- Data placement:
  - Output register empty, or being popped while RAM is empty: the push goes straight to the output register.
  - Otherwise the push writes RAM[wptr] and wptr advances.
  - Pop with RAM non-empty: output register loads RAM[rptr] and rptr advances.
- Latency: a word pushed into an empty FIFO at edge N appears on axis_mif.tvalid after edge N (one cycle).
- Throughput: 1 word/cycle sustained in any fill state when both sides are ready.
- Ordering is strictly FIFO, and axis_mif.tdata is stable while tvalid && !tready (AXIS rule).
- Simultaneous push and pop:
  - When 0 < count < DEPTH, count is unchanged.
  - When count == DEPTH, tready_q = 0, so only the pop occurs; tready rises the next cycle.
- Reset (rst = 1), taking effect at the next edge:
  - tvalid_q = 0, tdata_q = 0, count = 0, wptr = rptr = 0, tready_q = 0.
  - almost_empty = 1. almost_full = 0, except when AFULL_THRESH == 0 (illegal).
  - tready_q becomes 1 on the first edge with rst = 0.
- Reset mid-transfer drops all data. rst has priority over flush.
- Flush (flush = 1):
  - At the next edge: count = 0, pointers = 0, tvalid_q = 0, tready_q = 1.
  - Any push or pop handshake in the flush cycle is discarded, with no data written or popped.
  - tdata_q is not cleared.
  - Back-to-back flush cycles keep the FIFO empty.
- Flags update in the same cycle as count; no hysteresis.
- Elaboration checks ($fatal): DEPTH ≥ 2; thresholds within their legal ranges.

Test Plan:
- Reset release (DEPTH=5, W=32): hold rst 3 cycles → tvalid=0, tready=0, count=0, almost_empty=1 during reset; tready=1 on the first cycle after.
- Fill to full, mif.tready=0, push 0xA0..0xA4 → count 1..5; almost_full asserts at count=4; tready=0 after the 5th push; a 6th word held on sif is not accepted.
- Drain after full: mif.tready=1 → outputs 0xA0..0xA4 in order, one per cycle; tready returns 1 the cycle after the first pop; count ends at 0 with almost_empty=1.
- Streaming at count=3, both sides valid/ready for 20 cycles with an incrementing pattern → count stays 3; no gaps, drops or duplicates.
- Non-power-of-2 wrap, DEPTH=6: 17 random push/pop bursts with random tready → scoreboard matches exactly; wptr/rptr wrap 4 → 0 correctly.
- Flush with count=4 and a simultaneous push of 0xFF → next cycle count=0, tvalid=0, tready=1; 0xFF is never emitted; a following push of 0x11 emerges one cycle later.
